// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO I/O controller: bus width default, register map
// and active-low seven-segment glyphs (bit 6 = g ... bit 0 = a).
package mmio_pkg;

    localparam int MMIO_DBITS = 32;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCAP  = 32'hF000_0110;
    localparam logic [31:0] ADDR_KMASK = 32'hF000_0114;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to active-low seven-segment glyph, full 0-F hex set.
module seg7_decoder
    import mmio_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O block: output registers, synchronised/debounced keys with
// sticky press capture and maskable interrupt, switch sampling, HEX digit drive.
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter int DBITS           = MMIO_DBITS,
    parameter int NKEYS           = 4,
    parameter int NSW             = 10,
    parameter int NLEDR           = 10,
    parameter int NLEDG           = 8,
    parameter int NHEX            = 4,
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBITS-1:0]     addr,
    input  logic                 wr_en,
    input  logic [DBITS-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [DBITS-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 hit,
    input  logic [NKEYS-1:0]     key_in,
    input  logic [NSW-1:0]       sw_in,
    output logic [NLEDR-1:0]     ledr,
    output logic [NLEDG-1:0]     ledg,
    output logic [7*NHEX-1:0]    hex,
    output logic                 irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LIMIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [4*NHEX-1:0] r_hex;
    logic [NLEDR-1:0]  r_ledr;
    logic [NLEDG-1:0]  r_ledg;
    logic [NKEYS-1:0]  r_kcap, r_kmask;
    logic [NKEYS-1:0]  r_key_s1, r_key_s2;
    logic [NSW-1:0]    r_sw_s1, r_sw_s2;
    logic              r_irq, r_rd_valid;
    logic [DBITS-1:0]  r_rd_data;

    logic [NKEYS-1:0]  w_key_db, w_press, w_kcap_clr;
    logic [DBITS-1:0]  w_rd_mux;
    logic              w_sel_hex, w_sel_ledr, w_sel_ledg, w_sel_key;
    logic              w_sel_sw, w_sel_kcap, w_sel_kmask;
    logic              w_unused_wr_bits;

    assign w_sel_hex   = (addr == DBITS'(ADDR_HEX));
    assign w_sel_ledr  = (addr == DBITS'(ADDR_LEDR));
    assign w_sel_ledg  = (addr == DBITS'(ADDR_LEDG));
    assign w_sel_key   = (addr == DBITS'(ADDR_KEY));
    assign w_sel_sw    = (addr == DBITS'(ADDR_SW));
    assign w_sel_kcap  = (addr == DBITS'(ADDR_KCAP));
    assign w_sel_kmask = (addr == DBITS'(ADDR_KMASK));

    assign hit = w_sel_hex | w_sel_ledr | w_sel_ledg | w_sel_key |
                 w_sel_sw | w_sel_kcap | w_sel_kmask;

    assign w_kcap_clr       = (wr_en && w_sel_kcap) ? wr_data[NKEYS-1:0] : '0;
    assign w_unused_wr_bits = ^wr_data;

    // Keys idle high (released), so synchronisers come out of reset at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key_in;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw_in;
            r_sw_s2  <= r_sw_s1;
        end
    end

    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
        logic [CW-1:0] r_cnt;
        logic          r_db;
        logic          w_accept;

        assign w_accept     = (r_key_s2[gi] != r_db) && ((r_cnt + CNT_ONE) == DB_LIMIT);
        assign w_key_db[gi] = r_db;
        assign w_press[gi]  = w_accept && !r_key_s2[gi];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
                r_db  <= 1'b1;
            end else if (r_key_s2[gi] == r_db) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_db  <= r_key_s2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_sel_hex)   w_rd_mux[4*NHEX-1:0] = r_hex;
        if (w_sel_ledr)  w_rd_mux[NLEDR-1:0]  = r_ledr;
        if (w_sel_ledg)  w_rd_mux[NLEDG-1:0]  = r_ledg;
        if (w_sel_key)   w_rd_mux[NKEYS-1:0]  = ~w_key_db;
        if (w_sel_sw)    w_rd_mux[NSW-1:0]    = r_sw_s2;
        if (w_sel_kcap)  w_rd_mux[NKEYS-1:0]  = r_kcap;
        if (w_sel_kmask) w_rd_mux[NKEYS-1:0]  = r_kmask;
    end

    // A new press in the same cycle as a clear write keeps the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hex      <= '0;
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_kcap     <= '0;
            r_kmask    <= '0;
            r_irq      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (wr_en && w_sel_hex)   r_hex   <= wr_data[4*NHEX-1:0];
            if (wr_en && w_sel_ledr)  r_ledr  <= wr_data[NLEDR-1:0];
            if (wr_en && w_sel_ledg)  r_ledg  <= wr_data[NLEDG-1:0];
            if (wr_en && w_sel_kmask) r_kmask <= wr_data[NKEYS-1:0];
            r_kcap     <= (r_kcap & ~w_kcap_clr) | w_press;
            r_irq      <= |(r_kcap & r_kmask);
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_mux;
        end
    end

    for (genvar gd = 0; gd < NHEX; gd++) begin : g_hex
        seg7_decoder u_seg (
            .i_nibble (r_hex[4*gd +: 4]),
            .o_seg    (hex[7*gd +: 7])
        );
    end

    assign ledr     = r_ledr;
    assign ledg     = r_ledg;
    assign irq      = r_irq;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Randomised and directed bench for mmio_io_ctrl against a cycle-level reference model.
module tb_mmio_io_ctrl;

    localparam int DC = 4;
    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_LEDG  = 32'hF000_0008;
    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_KCAP  = 32'hF000_0110;
    localparam logic [31:0] A_KMASK = 32'hF000_0114;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wr_data, rd_data;
    logic        wr_en, rd_en, rd_valid, hit, irq;
    logic [3:0]  key_in;
    logic [9:0]  sw_in, ledr;
    logic [7:0]  ledg;
    logic [27:0] hex;

    always #5 clk = ~clk;

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .hit(hit),
        .key_in(key_in), .sw_in(sw_in), .ledr(ledr), .ledg(ledg), .hex(hex), .irq(irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state: what the registers hold after the most recent edge.
    logic [15:0] m_hex;
    logic [9:0]  m_ledr, m_sw1, m_sw2;
    logic [7:0]  m_ledg;
    logic [3:0]  m_kcap, m_kmask, m_db, m_ks1, m_ks2;
    int          m_run [4];
    logic        m_irq, m_rdv;
    logic [31:0] m_rdd;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] v);
        logic [27:0] h;
        for (int i = 0; i < 4; i++) h[7*i +: 7] = seg(v[4*i +: 4]);
        return h;
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return a inside {A_HEX, A_LEDR, A_LEDG, A_KEY, A_SW, A_KCAP, A_KMASK};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a)
            A_HEX:   return {16'h0, m_hex};
            A_LEDR:  return {22'h0, m_ledr};
            A_LEDG:  return {24'h0, m_ledg};
            A_KEY:   return {28'h0, ~m_db};
            A_SW:    return {22'h0, m_sw2};
            A_KCAP:  return {28'h0, m_kcap};
            A_KMASK: return {28'h0, m_kmask};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_ledg = '0; m_kcap = '0; m_kmask = '0;
        m_db = '1; m_ks1 = '1; m_ks2 = '1; m_sw1 = '0; m_sw2 = '0;
        m_irq = 1'b0; m_rdv = 1'b0; m_rdd = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    // One clock edge: everything is computed from the values held before the edge.
    task automatic model_step();
        logic [3:0] press;
        logic       nirq;
        press = '0;
        nirq  = |(m_kcap & m_kmask);
        if (rd_en) m_rdd = model_read(addr);
        m_rdv = rd_en;
        for (int i = 0; i < 4; i++) begin
            if (m_ks2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    if (m_ks2[i] == 1'b0) press[i] = 1'b1;
                    m_db[i]  = m_ks2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (wr_en) begin
            case (addr)
                A_HEX:   m_hex   = wr_data[15:0];
                A_LEDR:  m_ledr  = wr_data[9:0];
                A_LEDG:  m_ledg  = wr_data[7:0];
                A_KMASK: m_kmask = wr_data[3:0];
                A_KCAP:  m_kcap  = m_kcap & ~wr_data[3:0];
                default: ;
            endcase
        end
        m_kcap = m_kcap | press;
        m_irq  = nirq;
        m_ks2  = m_ks1; m_ks1 = key_in;
        m_sw2  = m_sw1; m_sw1 = sw_in;
    endtask

    task automatic compare_outputs();
        chk("ledr", 32'(ledr), 32'(m_ledr));
        chk("ledg", 32'(ledg), 32'(m_ledg));
        chk("hex", 32'(hex), 32'(exp_hex(m_hex)));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
        if (m_rdv) chk("rd_data", rd_data, m_rdd);
    endtask

    task automatic cycle();
        #1 chk("hit", 32'(hit), 32'(model_hit(addr)));
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b0;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        cycle();
        rd_en = 1'b0;
        chk(tag, rd_data, exp);
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic found;
        int   hold [4];
        int   sel;

        reset = 1'b0; addr = '0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0;
        key_in = '1; sw_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_outputs();
        chk("rst_hex", 32'(hex), 32'({4{7'b1000000}}));
        reset = 1'b1;
        rd_expect("rst_key", A_KEY, 32'h0);
        idle(1);

        wr(A_HEX, 32'h0000_BEEF);
        chk("hex_beef", 32'(hex), 32'({seg(4'hB), seg(4'hE), seg(4'hE), seg(4'hF)}));
        rd_expect("rd_hex", A_HEX, 32'h0000_BEEF);
        wr(A_LEDG, 32'hFFFF_FFFF);
        chk("ledg_ff", 32'(ledg), 32'h0000_00FF);
        rd_expect("rd_ledg", A_LEDG, 32'h0000_00FF);

        key_in[2] = 1'b0; idle(3); key_in[2] = 1'b1; idle(8);
        rd_expect("glitch_key", A_KEY, 32'h0);
        rd_expect("glitch_kcap", A_KCAP, 32'h0);

        wr(A_KMASK, 32'h4);
        key_in[2] = 1'b0; idle(8);
        rd_expect("press_key", A_KEY, 32'h4);
        rd_expect("press_kcap", A_KCAP, 32'h4);
        chk("irq_set", 32'(irq), 32'd1);
        wr(A_KCAP, 32'h4);
        idle(1);
        chk("irq_clr", 32'(irq), 32'd0);
        rd_expect("kcap_clr", A_KCAP, 32'h0);
        key_in[2] = 1'b1; idle(8);
        rd_expect("release_kcap", A_KCAP, 32'h0);
        rd_expect("release_key", A_KEY, 32'h0);

        key_in[2] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_ks2[2] == 1'b0 && m_db[2] == 1'b1 && m_run[2] == DC - 1) begin
                wr(A_KCAP, 32'h4);
                found = 1'b1;
            end else begin
                cycle();
            end
        end
        chk("coinc_found", 32'(found), 32'd1);
        rd_expect("coinc_kcap", A_KCAP, 32'h4);
        chk("irq_pre_rst", 32'(irq), 32'd1);

        wr(A_LEDR, 32'h3FF);
        key_in[1] = 1'b0; idle(5);
        #2 reset = 1'b0;
        #1;
        chk("arst_ledr", 32'(ledr), 32'h0);
        chk("arst_ledg", 32'(ledg), 32'h0);
        chk("arst_hex", 32'(hex), 32'({4{7'b1000000}}));
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_rdv", 32'(rd_valid), 32'd0);
        chk("arst_rdd", rd_data, 32'h0);
        model_reset();
        key_in = '1;
        @(negedge clk);
        reset = 1'b1;
        key_in[1] = 1'b0; idle(3); key_in[1] = 1'b1; idle(8);
        rd_expect("post_rst_key", A_KEY, 32'h0);
        rd_expect("post_rst_kcap", A_KCAP, 32'h0);

        sw_in = 10'h2A5; idle(3);
        rd_expect("rd_sw", A_SW, 32'h0000_02A5);
        addr = 32'hF000_0020;
        #1 chk("hit_unmapped", 32'(hit), 32'd0);
        rd_expect("rd_unmapped", 32'hF000_0020, 32'h0);
        wr(A_SW, 32'hFFFF_FFFF);
        rd_expect("sw_ro", A_SW, 32'h0000_02A5);

        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    key_in[i] = 1'($urandom_range(0, 1));
                    hold[i]   = $urandom_range(1, 10);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 15) == 0) sw_in = 10'($urandom);
            sel = $urandom_range(0, 8);
            case (sel)
                0: addr = A_HEX;   1: addr = A_LEDR; 2: addr = A_LEDG; 3: addr = A_KEY;
                4: addr = A_SW;    5: addr = A_KCAP; 6: addr = A_KMASK;
                7: addr = $urandom;
                default: addr = 32'hF000_0018;
            endcase
            wr_data = $urandom;
            wr_en   = ($urandom_range(0, 2) == 0);
            rd_en   = ($urandom_range(0, 1) == 0);
            cycle();
        end
        wr_en = 1'b0; rd_en = 1'b0; key_in = '1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
